// File: rtl/header_extract_if.sv
// rtl/header_extract_if.sv - Frame byte stream in, extracted IPv4/L4 header fields out
interface header_extract_if;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        sop_i;
    logic        eop_i;
    logic [31:0] in_ip_o;
    logic [31:0] out_ip_o;
    logic [7:0]  proto_o;
    logic [15:0] in_port_o;
    logic [15:0] out_port_o;
    logic        hdr_valid_o;
    logic        err_o;

    modport master (
        output data_i, valid_i, sop_i, eop_i,
        input  in_ip_o, out_ip_o, proto_o, in_port_o, out_port_o, hdr_valid_o, err_o
    );

    modport slave (
        input  data_i, valid_i, sop_i, eop_i,
        output in_ip_o, out_ip_o, proto_o, in_port_o, out_port_o, hdr_valid_o, err_o
    );
endinterface

// File: rtl/header_extract.sv
// rtl/header_extract.sv - Byte-stream IPv4/TCP/UDP header parser; HEADER_EXTRACT_VLAN_EN enables one 802.1Q tag
module header_extract #(
    parameter int CNT_W = 7
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    header_extract_if.slave  bus
);
    localparam int OW = (CNT_W > 7) ? CNT_W + 1 : 8;

    typedef enum logic [2:0] {IDLE, ETH, IP, L4, DRAIN} state_t;

    state_t            state_q, state_d, proc_state;
    logic [CNT_W-1:0]  off_q, off_d, cur;
    logic              vlan_q, vlan_d;
    logic [7:0]        ethhi_q, ethhi_d;
    logic [3:0]        ihl_q, ihl_d;
    logic [7:0]        proto_q, proto_d;
    logic [31:0]       src_q, src_d, dst_q, dst_d;
    logic [15:0]       sport_q, sport_d, dport_q, dport_d;
    logic [31:0]       in_ip_q, in_ip_d, out_ip_q, out_ip_d;
    logic [7:0]        proto_out_q, proto_out_d;
    logic [15:0]       in_port_q, in_port_d, out_port_q, out_port_d;
    logic              hv_q, hv_d, err_q, err_d;

    logic [OW-1:0]     off_w, base_w, hend_w, l4_w;
    logic [15:0]       etype;
    logic              tag_hit, done, l4_done, drop;

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        vlan_d      = vlan_q;
        ethhi_d     = ethhi_q;
        ihl_d       = ihl_q;
        proto_d     = proto_q;
        src_d       = src_q;
        dst_d       = dst_q;
        sport_d     = sport_q;
        dport_d     = dport_q;
        in_ip_d     = in_ip_q;
        out_ip_d    = out_ip_q;
        proto_out_d = proto_out_q;
        in_port_d   = in_port_q;
        out_port_d  = out_port_q;
        hv_d        = 1'b0;
        err_d       = 1'b0;
        proc_state  = state_q;
        cur         = off_q;
        done        = 1'b0;
        l4_done     = 1'b0;
        drop        = 1'b0;
        tag_hit     = 1'b0;
        etype       = {ethhi_q, bus.data_i};

        // A SOP byte always restarts parsing at offset 0, whatever state we were in.
        if (bus.valid_i && bus.sop_i) begin
            err_d      = (state_q == ETH) || (state_q == IP) || (state_q == L4);
            proc_state = ETH;
            cur        = '0;
            vlan_d     = 1'b0;
        end

        off_w  = OW'(cur);
        base_w = vlan_q ? OW'(18) : OW'(14);
        hend_w = base_w + OW'({ihl_q, 2'b00}) - OW'(1);
        l4_w   = hend_w + OW'(1);

        if (bus.valid_i && (proc_state != IDLE)) begin
            state_d = proc_state;
            off_d   = (cur == '1) ? cur : cur + CNT_W'(1);
            case (proc_state)
                ETH: begin
                    if (off_w == base_w - OW'(2)) ethhi_d = bus.data_i;
                    if (off_w == base_w - OW'(1)) begin
`ifdef HEADER_EXTRACT_VLAN_EN
                        tag_hit = !vlan_q && (etype == 16'h8100);
`endif
                        if (tag_hit)                    vlan_d  = 1'b1;
                        else if (etype == 16'h0800)     state_d = IP;
                        else                            drop    = 1'b1;
                    end
                end
                IP: begin
                    if (off_w == base_w) begin
                        ihl_d = bus.data_i[3:0];
                        drop  = (bus.data_i[7:4] != 4'd4) || (bus.data_i[3:0] < 4'd5);
                    end
                    if (off_w == base_w + OW'(9)) proto_d = bus.data_i;
                    if (off_w >= base_w + OW'(12) && off_w <= base_w + OW'(15))
                        src_d = {src_q[23:0], bus.data_i};
                    if (off_w >= base_w + OW'(16) && off_w <= base_w + OW'(19))
                        dst_d = {dst_q[23:0], bus.data_i};
                    // ihl_q is only meaningful once the version/IHL byte has been taken.
                    if (off_w != base_w && off_w == hend_w) begin
                        if (proto_d == 8'h06 || proto_d == 8'h11) state_d = L4;
                        else                                      done    = 1'b1;
                    end
                end
                L4: begin
                    if (off_w == l4_w || off_w == l4_w + OW'(1))
                        sport_d = {sport_q[7:0], bus.data_i};
                    if (off_w == l4_w + OW'(2) || off_w == l4_w + OW'(3))
                        dport_d = {dport_q[7:0], bus.data_i};
                    if (off_w == l4_w + OW'(3)) begin
                        done    = 1'b1;
                        l4_done = 1'b1;
                    end
                end
                default: ;
            endcase

            if (done) begin
                hv_d        = 1'b1;
                in_ip_d     = src_d;
                out_ip_d    = dst_d;
                proto_out_d = proto_d;
                in_port_d   = l4_done ? sport_d : 16'h0000;
                out_port_d  = l4_done ? dport_d : 16'h0000;
                state_d     = bus.eop_i ? IDLE : DRAIN;
            end else if (drop) begin
                state_d = bus.eop_i ? IDLE : DRAIN;
            end else if (bus.eop_i) begin
                err_d   = err_d || (proc_state != DRAIN);
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            off_q       <= '0;
            vlan_q      <= 1'b0;
            ethhi_q     <= 8'h00;
            ihl_q       <= 4'h0;
            proto_q     <= 8'h00;
            src_q       <= 32'h0;
            dst_q       <= 32'h0;
            sport_q     <= 16'h0;
            dport_q     <= 16'h0;
            in_ip_q     <= 32'h0;
            out_ip_q    <= 32'h0;
            proto_out_q <= 8'h00;
            in_port_q   <= 16'h0;
            out_port_q  <= 16'h0;
            hv_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            vlan_q      <= vlan_d;
            ethhi_q     <= ethhi_d;
            ihl_q       <= ihl_d;
            proto_q     <= proto_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            sport_q     <= sport_d;
            dport_q     <= dport_d;
            in_ip_q     <= in_ip_d;
            out_ip_q    <= out_ip_d;
            proto_out_q <= proto_out_d;
            in_port_q   <= in_port_d;
            out_port_q  <= out_port_d;
            hv_q        <= hv_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ip_o     = in_ip_q;
    assign bus.out_ip_o    = out_ip_q;
    assign bus.proto_o     = proto_out_q;
    assign bus.in_port_o   = in_port_q;
    assign bus.out_port_o  = out_port_q;
    assign bus.hdr_valid_o = hv_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_header_extract.sv
// tb/tb_header_extract.sv - Randomized self-checking bench for header_extract
module tb_header_extract;
    localparam int K_NONE = 0;
    localparam int K_HDR  = 1;
    localparam int K_ERR  = 2;
`ifdef HEADER_EXTRACT_VLAN_EN
    localparam bit VLAN_ON = 1'b1;
`else
    localparam bit VLAN_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    header_extract_if bus ();
    header_extract #(.CNT_W(7)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    logic [7:0]  fb [0:255];
    int          m_kind, m_trig;
    logic [31:0] m_src, m_dst;
    logic [7:0]  m_proto;
    logic [15:0] m_sp, m_dp;
    logic [31:0] e_src, e_dst;
    logic [7:0]  e_proto;
    logic [15:0] e_sp, e_dp;
    bit          pend_abandon;
    int          got_hv, got_err;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic build_frame(input bit tag, input logic [15:0] et, input logic [3:0] ver,
                               input logic [3:0] ihl, input logic [7:0] proto,
                               input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] sp, input logic [15:0] dp);
        int b;
        int l;
        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
        b = 14;
        if (tag) begin
            fb[12] = 8'h81;
            fb[13] = 8'h00;
            b = 18;
        end
        fb[b-2] = et[15:8];
        fb[b-1] = et[7:0];
        fb[b]   = {ver, ihl};
        fb[b+9] = proto;
        for (int k = 0; k < 4; k++) begin
            fb[b+12+k] = src[31-8*k -: 8];
            fb[b+16+k] = dst[31-8*k -: 8];
        end
        if (ihl >= 4'd5) begin
            l = b + 4 * int'(ihl);
            fb[l]   = sp[15:8];
            fb[l+1] = sp[7:0];
            fb[l+2] = dp[15:8];
            fb[l+3] = dp[7:0];
        end
    endtask

    // Outcome of a frame of len bytes straight from the header layout rules.
    task automatic run_model(input int len);
        int base;
        int ihl;
        int hend;
        logic [15:0] et;
        m_kind = K_NONE; m_trig = -1;
        m_src = 0; m_dst = 0; m_proto = 0; m_sp = 0; m_dp = 0;
        base = 14;
        if (len < 14) begin m_kind = K_ERR; m_trig = len - 1; return; end
        et = {fb[12], fb[13]};
        if (VLAN_ON && et == 16'h8100) begin
            base = 18;
            if (len < 18) begin m_kind = K_ERR; m_trig = len - 1; return; end
            et = {fb[16], fb[17]};
        end
        if (et != 16'h0800) return;
        if (len < base + 1) begin m_kind = K_ERR; m_trig = len - 1; return; end
        if (fb[base][7:4] != 4'd4 || fb[base][3:0] < 4'd5) return;
        ihl  = int'(fb[base][3:0]);
        hend = base + 4 * ihl - 1;
        if (len < hend + 1) begin m_kind = K_ERR; m_trig = len - 1; return; end
        m_proto = fb[base+9];
        m_src   = {fb[base+12], fb[base+13], fb[base+14], fb[base+15]};
        m_dst   = {fb[base+16], fb[base+17], fb[base+18], fb[base+19]};
        if (m_proto != 8'h06 && m_proto != 8'h11) begin
            m_kind = K_HDR; m_trig = hend; return;
        end
        if (len < hend + 5) begin m_kind = K_ERR; m_trig = len - 1; return; end
        m_sp   = {fb[hend+1], fb[hend+2]};
        m_dp   = {fb[hend+3], fb[hend+4]};
        m_kind = K_HDR;
        m_trig = hend + 4;
    endtask

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic send_frame(input int len, input bit eop_last, input int gap_pct);
        int  g;
        bit  exp_hv, exp_er;
        run_model(len);
        got_hv = -1;
        got_err = -1;
        for (int i = 0; i < len; i++) begin
            g = (gap_pct > 0 && $urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
            repeat (g) begin
                bus.valid_i = 1'b0; bus.sop_i = 1'b0; bus.eop_i = 1'b0; bus.data_i = 8'($urandom);
                @(posedge clk); #1;
                n_checks++;
                if (bus.hdr_valid_o !== 1'b0 || bus.err_o !== 1'b0)
                    $display("FAIL gap_strobe: hdr_valid=%b err=%b required 0 0", bus.hdr_valid_o, bus.err_o);
            end
            bus.valid_i = 1'b1;
            bus.sop_i   = (i == 0);
            bus.eop_i   = eop_last && (i == len - 1);
            bus.data_i  = fb[i];
            @(posedge clk); #1;
            exp_hv = (m_kind == K_HDR) && (i == m_trig);
            exp_er = ((m_kind == K_ERR) && eop_last && (i == m_trig)) || (i == 0 && pend_abandon);
            n_checks++;
            if (bus.hdr_valid_o !== exp_hv) begin
                n_fail++;
                $display("FAIL hdr_valid byte %0d: got %b required %b", i, bus.hdr_valid_o, exp_hv);
            end
            n_checks++;
            if (bus.err_o !== exp_er) begin
                n_fail++;
                $display("FAIL err byte %0d: got %b required %b", i, bus.err_o, exp_er);
            end
            if (bus.hdr_valid_o === 1'b1) got_hv = i;
            if (bus.err_o === 1'b1) got_err = i;
            if (exp_hv) begin
                e_src = m_src; e_dst = m_dst; e_proto = m_proto; e_sp = m_sp; e_dp = m_dp;
            end
        end
        bus.valid_i = 1'b0; bus.sop_i = 1'b0; bus.eop_i = 1'b0;
        pend_abandon = !eop_last && (m_kind == K_ERR);
        n_checks++;
        if (bus.in_ip_o !== e_src || bus.out_ip_o !== e_dst || bus.proto_o !== e_proto ||
            bus.in_port_o !== e_sp || bus.out_port_o !== e_dp) begin
            n_fail++;
            $display("FAIL fields: got %h %h %h %h %h required %h %h %h %h %h",
                     bus.in_ip_o, bus.out_ip_o, bus.proto_o, bus.in_port_o, bus.out_port_o,
                     e_src, e_dst, e_proto, e_sp, e_dp);
        end
    endtask

    task automatic spec_tcp();
        build_frame(1'b0, 16'h0800, 4'd4, 4'd5, 8'h06, 32'h0a010003, 32'h0a010203, 16'd21, 16'd5000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.valid_i = 1'b0; bus.sop_i = 1'b0; bus.eop_i = 1'b0; bus.data_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.in_ip_o, bus.out_ip_o, bus.proto_o, bus.in_port_o, bus.out_port_o,
             bus.hdr_valid_o, bus.err_o} !== 106'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h %h %h %h %h %b %b required all 0", bus.in_ip_o,
                     bus.out_ip_o, bus.proto_o, bus.in_port_o, bus.out_port_o, bus.hdr_valid_o, bus.err_o);
        end
        rst_n = 1'b1;
        e_src = 0; e_dst = 0; e_proto = 0; e_sp = 0; e_dp = 0;
        pend_abandon = 1'b0;
    endtask

    task automatic test_tcp();
        spec_tcp();
        send_frame(64, 1'b1, 0);
        n_checks++;
        if (got_hv !== 37) begin n_fail++; $display("FAIL tcp_strobe_offset: got %0d required 37", got_hv); end
        n_checks++;
        if (bus.in_ip_o !== 32'h0a010003 || bus.out_ip_o !== 32'h0a010203 || bus.proto_o !== 8'h06 ||
            bus.in_port_o !== 16'h0015 || bus.out_port_o !== 16'h1388) begin
            n_fail++;
            $display("FAIL tcp_fields: got %h %h %h %h %h required 0a010003 0a010203 06 0015 1388",
                     bus.in_ip_o, bus.out_ip_o, bus.proto_o, bus.in_port_o, bus.out_port_o);
        end
    endtask

    task automatic test_udp_ihl6();
        build_frame(1'b0, 16'h0800, 4'd4, 4'd6, 8'h11, $urandom, $urandom, 16'($urandom), 16'd123);
        send_frame(70, 1'b1, 25);
        n_checks++;
        if (got_hv !== 41 || bus.out_port_o !== 16'h007b) begin
            n_fail++;
            $display("FAIL udp_ihl6: strobe at %0d port %h required 41 007b", got_hv, bus.out_port_o);
        end
    endtask

    task automatic test_icmp();
        build_frame(1'b0, 16'h0800, 4'd4, 4'd5, 8'h01, $urandom, $urandom, 16'hffff, 16'hffff);
        send_frame(60, 1'b1, 0);
        n_checks++;
        if (got_hv !== 33 || bus.in_port_o !== 16'h0 || bus.out_port_o !== 16'h0) begin
            n_fail++;
            $display("FAIL icmp: strobe at %0d ports %h %h required 33 0000 0000", got_hv, bus.in_port_o, bus.out_port_o);
        end
    endtask

    task automatic test_drop();
        build_frame(1'b0, 16'h86dd, 4'd4, 4'd5, 8'h06, $urandom, $urandom, 16'd1, 16'd2);
        send_frame(64, 1'b1, 10);
        n_checks++;
        if (got_hv !== -1 || got_err !== -1) begin
            n_fail++;
            $display("FAIL non_ipv4: strobe %0d err %0d required none none", got_hv, got_err);
        end
        build_frame(1'b0, 16'h0800, 4'd6, 4'd5, 8'h06, $urandom, $urandom, 16'd1, 16'd2);
        send_frame(64, 1'b1, 0);
        n_checks++;
        if (got_hv !== -1 || got_err !== -1) begin
            n_fail++;
            $display("FAIL bad_version: strobe %0d err %0d required none none", got_hv, got_err);
        end
    endtask

    task automatic test_truncated();
        spec_tcp();
        send_frame(64, 1'b1, 0);
        build_frame(1'b0, 16'h0800, 4'd4, 4'd5, 8'h11, 32'h01020304, 32'h05060708, 16'd7, 16'd9);
        send_frame(31, 1'b1, 0);
        n_checks++;
        if (got_err !== 30 || bus.in_ip_o !== 32'h0a010003 || bus.out_port_o !== 16'h1388) begin
            n_fail++;
            $display("FAIL truncated: err at %0d in_ip %h out_port %h required 30 0a010003 1388",
                     got_err, bus.in_ip_o, bus.out_port_o);
        end
        send_frame(1, 1'b1, 0);
        n_checks++;
        if (got_err !== 0 || got_hv !== -1) begin
            n_fail++;
            $display("FAIL sop_eop: err %0d strobe %0d required 0 none", got_err, got_hv);
        end
    endtask

    task automatic test_restart();
        build_frame(1'b0, 16'h0800, 4'd4, 4'd5, 8'h06, $urandom, $urandom, 16'd3, 16'd4);
        send_frame(20, 1'b0, 0);
        spec_tcp();
        send_frame(64, 1'b1, 0);
        n_checks++;
        if (got_err !== 0 || got_hv !== 37 || bus.in_ip_o !== 32'h0a010003) begin
            n_fail++;
            $display("FAIL restart: err %0d strobe %0d in_ip %h required 0 37 0a010003", got_err, got_hv, bus.in_ip_o);
        end
    endtask

    task automatic test_vlan();
        int want;
        want = VLAN_ON ? 41 : -1;
        build_frame(1'b1, 16'h0800, 4'd4, 4'd5, 8'h06, 32'hc0a80001, 32'hc0a80002, 16'd80, 16'd443);
        send_frame(70, 1'b1, 15);
        n_checks++;
        if (got_hv !== want || got_err !== -1) begin
            n_fail++;
            $display("FAIL vlan: strobe %0d err %0d required %0d none", got_hv, got_err, want);
        end
    endtask

    task automatic test_long();
        spec_tcp();
        send_frame(200, 1'b1, 0);
        build_frame(1'b0, 16'h0800, 4'd4, 4'd5, 8'h11, $urandom, $urandom, 16'($urandom), 16'($urandom));
        send_frame(45, 1'b1, 30);
        n_checks++;
        if (got_hv !== 37) begin n_fail++; $display("FAIL after_long: strobe %0d required 37", got_hv); end
    endtask

    task automatic rand_frame(input bit force_eop, input int gap_pct);
        bit          tag;
        logic [15:0] et;
        logic [3:0]  ver, ihl;
        logic [7:0]  proto;
        int          full, len;
        bit          eop_last;
        tag   = ($urandom_range(3) == 0);
        et    = ($urandom_range(9) < 8) ? 16'h0800 : 16'h86dd;
        ver   = ($urandom_range(9) < 9) ? 4'd4 : 4'd6;
        ihl   = ($urandom_range(9) < 9) ? 4'($urandom_range(5, 8)) : 4'($urandom_range(0, 4));
        case ($urandom_range(3))
            0: proto = 8'h06;
            1: proto = 8'h11;
            2: proto = 8'h01;
            default: proto = 8'($urandom);
        endcase
        build_frame(tag, et, ver, ihl, proto, $urandom, $urandom, 16'($urandom), 16'($urandom));
        full = 14 + (tag ? 4 : 0) + 4 * int'(ihl) + 4 + $urandom_range(0, 20);
        len  = ($urandom_range(3) != 0) ? full : $urandom_range(1, full);
        eop_last = force_eop || ($urandom_range(6) != 0);
        send_frame(len, eop_last, gap_pct);
    endtask

    task automatic test_back_to_back();
        spec_tcp();
        send_frame(38, 1'b1, 0);
        spec_tcp();
        send_frame(38, 1'b1, 0);
        n_checks++;
        if (got_hv !== 37 || got_err !== -1) begin
            n_fail++;
            $display("FAIL b2b_eop_on_last: strobe %0d err %0d required 37 none", got_hv, got_err);
        end
        for (int f = 0; f < 8; f++) rand_frame(f == 7, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 60; f++) rand_frame(f == 59, 20);
    endtask

    task automatic test_reset_mid_l4();
        spec_tcp();
        send_frame(36, 1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.in_ip_o, bus.out_ip_o, bus.proto_o, bus.in_port_o, bus.out_port_o,
             bus.hdr_valid_o, bus.err_o} !== 106'd0) begin
            n_fail++;
            $display("FAIL reset_mid_l4: got %h %h %h %h %h %b %b required all 0", bus.in_ip_o,
                     bus.out_ip_o, bus.proto_o, bus.in_port_o, bus.out_port_o, bus.hdr_valid_o, bus.err_o);
        end
        rst_n = 1'b1;
        pend_abandon = 1'b0;
        e_src = 0; e_dst = 0; e_proto = 0; e_sp = 0; e_dp = 0;
        bus.valid_i = 1'b1; bus.sop_i = 1'b0; bus.eop_i = 1'b0; bus.data_i = 8'h45;
        repeat (2) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.hdr_valid_o !== 1'b0 || bus.err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_non_sop: hdr_valid %b err %b required 0 0", bus.hdr_valid_o, bus.err_o);
            end
        end
        bus.valid_i = 1'b0;
        spec_tcp();
        send_frame(64, 1'b1, 0);
        n_checks++;
        if (got_hv !== 37 || got_err !== -1) begin
            n_fail++;
            $display("FAIL after_reset_frame: strobe %0d err %0d required 37 none", got_hv, got_err);
        end
    endtask

    initial begin
        test_reset();
        test_tcp();
        test_udp_ihl6();
        test_icmp();
        test_drop();
        test_truncated();
        test_restart();
        test_vlan();
        test_long();
        test_back_to_back();
        test_random();
        test_reset_mid_l4();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
